// File: rtl/sev_seg_mux.sv
// sev_seg_mux: multiplexed 7-segment driver (clk, rst async high; data/dp_in/load shadowed, blank_lz live; seg/dp/an active-low, registered)
module sev_seg_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int HEX         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dps_q, an_q, an_d, lz;
  logic [6:0]            seg_q, seg_d, enc;
  logic                  dpo_q, dpo_d, wrap, dsel, zsel;
  logic [3:0]            nib;
  always_comb begin
    wrap    = presc_q == PW'(REFRESH_DIV - 1);
    presc_d = wrap ? '0 : presc_q + PW'(1);
    idx_d   = (DIGITS == 1 || !wrap) ? idx_q : (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1));
    lz      = '0;
    nib     = '0;
    dsel    = 1'b0;
    zsel    = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      lz[k] = (data_q >> (4 * k)) == '0;
      if (idx_q == IW'(k)) begin
        nib  = data_q[4*k +: 4];
        dsel = dps_q[k];
        zsel = lz[k] && k != 0;
      end
    end
    case (nib)
      4'h0: enc = 7'b0000001;
      4'h1: enc = 7'b1001111;
      4'h2: enc = 7'b0010010;
      4'h3: enc = 7'b0000110;
      4'h4: enc = 7'b1001100;
      4'h5: enc = 7'b0100100;
      4'h6: enc = 7'b0100000;
      4'h7: enc = 7'b0001111;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0000100;
      4'hA: enc = 7'b0001000;
      4'hB: enc = 7'b1100000;
      4'hC: enc = 7'b0110001;
      4'hD: enc = 7'b1000010;
      4'hE: enc = 7'b0110000;
      default: enc = 7'b0111000;
    endcase
    seg_d = ((blank_lz && zsel) || (HEX == 0 && nib > 4'd9)) ? '1 : enc;
    // all digits off for the clock the index moves, so the old pattern never ghosts onto the new digit
    an_d  = (wrap && DIGITS > 1) ? '1 : ~(DIGITS'(1) << idx_q);
    dpo_d = ~dsel;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      dps_q   <= '0;
      seg_q   <= '1;
      dpo_q   <= 1'b1;
      an_q    <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (load) begin
        data_q <= data;
        dps_q  <= dp_in;
      end
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      an_q    <= an_d;
    end
  end
  assign seg = seg_q;
  assign dp  = dpo_q;
  assign an  = an_q;
endmodule

// File: doc/sev_seg_mux.md
SEV_SEG_MUX -- requirements
Module: sev_seg_mux

Interface
REQ-001 Parameters SHALL be, one per line:
- DIGITS, 4, number of digits driven (1..8).
- REFRESH_DIV, 1000, clocks each digit is shown (2..2^20).
- HEX, 1, 1 = show 0-F; 0 = decimal only, values 10-15 blank.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  4*DIGITS  nibble per digit; digit 0 = data[3:0] (rightmost).
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- load  in  1  1 = capture data and dp_in this clock.
- blank_lz  in  1  1 = suppress leading zeros.
- seg  out  7  segA-segG, seg[6]=segA .. seg[0]=segG, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  digit enables, active-low, one-hot-low or all-high.
REQ-003 The clock and reset SHALL be the only clock and reset: one clock, reset asynchronous and active-high.

Function
REQ-004 On a rising clk with load=1, the block SHALL register data and dp_in into shadow registers. Loads arriving mid-scan SHALL take effect from the next registered output update.
REQ-005 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap. The digit index SHALL advance by 1 when the prescaler is at REFRESH_DIV-1, wrapping from DIGITS-1 to 0.
REQ-006 Outputs seg, dp and an SHALL be registered. They SHALL reflect the index and shadow registers with exactly one clock of latency.
REQ-007 For the current index i, an SHALL have bit i low and all other bits high, except during the guard cycle (REQ-008).
REQ-008 Guard cycle: in the clock where the index changes, an SHALL be all ones for one clock, to prevent ghosting. The new digit SHALL then be enabled.
REQ-009 Segment encoding (segA..segG, 0 = lit) SHALL be:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
REQ-010 With HEX=1, the encoding SHALL also include:
- A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
REQ-011 With HEX=0, nibble values 10-15 SHALL drive seg=1111111, while an still selects the digit.
REQ-012 With blank_lz=1, digit i>0 SHALL drive seg=1111111 when its nibble and every higher nibble are zero. Digit 0 SHALL never be blanked.
REQ-013 dp SHALL be ~dp_shadow[i], independent of blanking.
REQ-014 blank_lz SHALL be sampled live, not shadowed.
REQ-015 With DIGITS=1, the index SHALL stay 0, the guard cycle SHALL not occur, and an SHALL be 0 after the first post-reset clock.
REQ-016 The prescaler and index widths SHALL be $clog2 sized. No counter SHALL exceed its range for any legal parameter.

Reset
REQ-017 While rst=1, the block SHALL hold:
- prescaler=0, index=0, shadow data=0, shadow dp=0
- seg=1111111, dp=1, an=all ones
REQ-018 Reset asserted mid-scan SHALL take effect immediately, without waiting for a clock edge.
REQ-019 After reset release, the first rising clk SHALL load the registered outputs for index 0, with no guard cycle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- DIGITS=4, REFRESH_DIV=4, load data=16'h1234, blank_lz=0 -> an cycles 1110,1101,1011,0111 with seg 1001100(4),0000110(3),0010010(2),1001111(1), with one an=1111 clock at each change.
- HEX=1, data=16'hABCD -> digit 0 seg=1000010, digit 3 seg=0001000; with HEX=0 all four digits show seg=1111111.
- blank_lz=1, data=16'h0050 -> digits 3 and 2 seg=1111111, digit 1 seg=0100100, digit 0 seg=0000001; data=16'h0000 -> only digit 0 lit, seg=0000001.
- dp_in=4'b0100 with blank_lz=1 and data=16'h0007 -> dp=0 only while an=1011, even though that digit's seg is blank.
- Load 16'h1111 then 16'h8888 mid-digit -> seg changes from 1001111 to 0000000 exactly one clock after the load edge.
- Assert rst asynchronously mid-scan -> an=1111, seg=1111111, dp=1 before the next clk edge; after release, an=1110 after one clock.
REQ-021 The bench SHALL formally check, for all inputs:
- an is all-ones or has exactly one low bit.
- The guard cycle is exactly one clock.
- The index never exceeds DIGITS-1.
